// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA CBC controller.
// Widths follow the TEA core's 64-bit block and 128-bit key.
package tea_pkg;

    localparam int TEA_ROUNDS = 32;
    localparam int BLK_W      = 64;
    localparam int KEY_W      = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        KEY_HI,
        KEY_LO,
        READY,
        WRITE,
        RUN,
        OUT
    } state_t;

endpackage

// File: rtl/tea_cbc_ctrl.sv
// CBC chaining controller driving the pins of a TEA core.
// Loads the key, chains blocks through the core, streams results.
module tea_cbc_ctrl
    import tea_pkg::*;
#(
    parameter int ROUNDS = TEA_ROUNDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key,
    input  logic             key_load,
    input  logic [BLK_W-1:0] iv,
    input  logic             iv_load,
    input  logic [BLK_W-1:0] s_data,
    input  logic             s_mode,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [BLK_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             key_ok,
    output logic             busy,
    output logic [BLK_W-1:0] core_in,
    output logic             core_mode,
    output logic             core_reset,
    output logic             core_write,
    input  logic [BLK_W-1:0] core_out,
    input  logic             core_out_ready
);

    localparam int CNT_W = $clog2(ROUNDS + 4);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROUNDS + 3);

    state_t           state;
    state_t           state_nx;
    logic [KEY_W-1:0] key_r;
    logic [BLK_W-1:0] chain;
    logic [BLK_W-1:0] blk_r;
    logic             mode_r;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             capture;

    assign core_mode = mode_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        busy       = 1'b1;
        core_reset = 1'b0;
        core_write = 1'b0;
        core_in    = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (key_load) state_nx = KEY_HI;
            end
            KEY_HI: begin
                core_reset = 1'b1;
                core_in    = key_r[KEY_W-1:BLK_W];
                state_nx   = KEY_LO;
            end
            KEY_LO: begin
                core_in  = key_r[BLK_W-1:0];
                state_nx = READY;
            end
            READY: begin
                busy    = 1'b0;
                s_ready = ~key_load & ~iv_load;
                accept  = s_valid & ~key_load & ~iv_load;
                if (key_load) state_nx = KEY_HI;
                else if (accept) state_nx = WRITE;
            end
            WRITE: begin
                core_write = 1'b1;
                core_in    = (mode_r == MODE_ENC) ? (blk_r ^ chain) : blk_r;
                state_nx   = RUN;
            end
            RUN: begin
                if (core_out_ready) begin
                    capture  = 1'b1;
                    state_nx = OUT;
                end else if (cnt == CNT_MAX) begin
                    // Core never answered: drop the block, keep the chain.
                    state_nx = READY;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) state_nx = READY;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_r  <= '0;
            chain  <= '0;
            blk_r  <= '0;
            mode_r <= MODE_ENC;
            cnt    <= '0;
            m_data <= '0;
            key_ok <= 1'b0;
        end else begin
            if ((state == IDLE || state == READY) && key_load) begin
                key_r <= key;
            end
            if (state == KEY_LO) key_ok <= 1'b1;
            if (state == READY && !key_load && iv_load) chain <= iv;
            if (accept) begin
                blk_r  <= s_data;
                mode_r <= s_mode;
            end
            if (state == WRITE) cnt <= '0;
            else if (state == RUN) cnt <= cnt + CNT_W'(1);
            if (capture) begin
                if (mode_r == MODE_ENC) begin
                    m_data <= core_out;
                    chain  <= core_out;
                end else begin
                    m_data <= core_out ^ chain;
                    chain  <= blk_r;
                end
            end
        end
    end

endmodule
